// File: rtl/ot_pkg.sv
// ot_pkg: shared state encoding, byte width and word-size helper for the OT sender.
package ot_pkg;
    typedef enum logic [2:0] {IDLE, RAND, TX_HDR, RX_V, PACK, TX_PK, DONE} state_t;
    localparam int BYTE_W = 8;
    function automatic int bytes_per_word(input int w);
        return w / BYTE_W;
    endfunction
endpackage

// File: rtl/ot_word_serializer.sv
// ot_word_serializer: loads one word and streams it LSB byte first on a valid/ready byte link.
module ot_word_serializer import ot_pkg::*; #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    output logic              ready,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_data
);
    localparam int BPW = bytes_per_word(WORD_W);
    localparam int BW = $clog2(BPW);
    logic [WORD_W-1:0] hold;
    logic [BW-1:0] cnt;
    logic fire, last;
    assign fire = tx_valid && tx_ready;
    assign last = cnt == BW'(BPW - 1);
    // a new word may be loaded in the same cycle the final byte leaves, keeping 1 byte/cycle
    assign ready = !tx_valid || (fire && last);
    assign tx_data = hold[BYTE_W-1:0];
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_valid <= 1'b0;
            hold <= '0;
            cnt <= '0;
        end else if (load && ready) begin
            tx_valid <= 1'b1;
            hold <= word;
            cnt <= '0;
        end else if (fire) begin
            tx_valid <= !last;
            hold <= hold >> BYTE_W;
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ot_sender_nway.sv
// ot_sender_nway: 1-out-of-NUM_MSG oblivious-transfer sender session controller.
// Define OT_RX_TIMEOUT_EN to abort a session whose RX word stalls for TIMEOUT_CYC cycles.
module ot_sender_nway import ot_pkg::*; #(
    parameter int WORD_W = 32,
    parameter int NUM_MSG = 2,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [WORD_W-1:0]           key_n,
    input  logic [WORD_W-1:0]           key_e,
    input  logic [NUM_MSG*WORD_W-1:0]   msgs,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        rng_req,
    input  logic                        rng_ack,
    input  logic [WORD_W-1:0]           rng_data,
    output logic                        pack_req,
    input  logic                        pack_ack,
    output logic [$clog2(NUM_MSG)-1:0]  pack_idx,
    output logic [WORD_W-1:0]           pack_v,
    output logic [WORD_W-1:0]           pack_x,
    output logic [WORD_W-1:0]           pack_m,
    input  logic [WORD_W-1:0]           pack_result,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic [7:0]                  tx_data,
    input  logic                        rx_valid,
    output logic                        rx_ready,
    input  logic [7:0]                  rx_data
);
    localparam int BPW = bytes_per_word(WORD_W);
    localparam int IW = $clog2(NUM_MSG);
    localparam int CW = $clog2(NUM_MSG + 3);
    localparam int BW = $clog2(BPW);
    state_t state;
    logic [WORD_W-1:0] n_r, e_r, v_r, word;
    logic [NUM_MSG*WORD_W-1:0] m_r;
    logic [WORD_W-1:0] x_r [NUM_MSG];
    logic [WORD_W-1:0] p_r [NUM_MSG];
    logic [CW-1:0] cnt, nwords, xi;
    logic [IW-1:0] idx;
    logic [BW-1:0] bcnt;
    logic tx_phase, ser_ready, load, rx_fire, timeout;
    assign idx = cnt[IW-1:0];
    assign xi = cnt - CW'(2);
    assign tx_phase = state == TX_HDR || state == TX_PK;
    assign nwords = state == TX_HDR ? CW'(NUM_MSG + 2) : CW'(NUM_MSG);
    assign word = state == TX_PK ? p_r[idx] : cnt == '0 ? n_r : cnt == CW'(1) ? e_r : x_r[xi[IW-1:0]];
    assign load = tx_phase && ser_ready && cnt != nwords;
    assign rx_ready = state == RX_V;
    assign rx_fire = rx_valid && rx_ready;
    assign busy = state != IDLE && state != DONE;
    assign done = state == DONE;
    assign pack_idx = pack_req ? idx : '0;
    assign pack_v = pack_req ? v_r : '0;
    assign pack_x = pack_req ? x_r[idx] : '0;
    assign pack_m = pack_req ? m_r[idx*WORD_W +: WORD_W] : '0;
`ifdef OT_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;
    always_ff @(posedge clk) begin
        if (reset || state != RX_V || rx_fire)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end
    assign timeout = state == RX_V && !rx_fire && tcnt == TW'(TIMEOUT_CYC - 1);
`else
    assign timeout = TIMEOUT_CYC < 0;
`endif
    always_ff @(posedge clk) begin
        err <= reset ? 1'b0 : timeout;
    end
    ot_word_serializer #(.WORD_W(WORD_W)) u_ser (
        .clk(clk),
        .reset(reset),
        .load(load),
        .word(word),
        .ready(ser_ready),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_data(tx_data)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            bcnt <= '0;
            rng_req <= 1'b0;
            pack_req <= 1'b0;
            n_r <= '0;
            e_r <= '0;
            v_r <= '0;
            m_r <= '0;
            for (int i = 0; i < NUM_MSG; i++) begin
                x_r[i] <= '0;
                p_r[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (start) begin
                    n_r <= key_n;
                    e_r <= key_e;
                    m_r <= msgs;
                    cnt <= '0;
                    rng_req <= 1'b1;
                    state <= RAND;
                end
                RAND: if (rng_req && rng_ack) begin
                    x_r[idx] <= rng_data;
                    rng_req <= 1'b0;
                    cnt <= cnt == CW'(NUM_MSG - 1) ? '0 : cnt + 1'b1;
                    state <= cnt == CW'(NUM_MSG - 1) ? TX_HDR : RAND;
                end else begin
                    rng_req <= 1'b1;
                end
                TX_HDR, TX_PK: if (load) begin
                    cnt <= cnt + 1'b1;
                end else if (cnt == nwords && !tx_valid) begin
                    cnt <= '0;
                    bcnt <= '0;
                    state <= state == TX_HDR ? RX_V : DONE;
                end
                RX_V: if (timeout) begin
                    state <= IDLE;
                end else if (rx_fire) begin
                    v_r <= {rx_data, v_r[WORD_W-1:BYTE_W]};
                    bcnt <= bcnt == BW'(BPW - 1) ? '0 : bcnt + 1'b1;
                    if (bcnt == BW'(BPW - 1)) begin
                        cnt <= '0;
                        pack_req <= 1'b1;
                        state <= PACK;
                    end
                end
                PACK: if (pack_req && pack_ack) begin
                    p_r[idx] <= pack_result;
                    pack_req <= 1'b0;
                    cnt <= cnt == CW'(NUM_MSG - 1) ? '0 : cnt + 1'b1;
                    state <= cnt == CW'(NUM_MSG - 1) ? TX_PK : PACK;
                end else begin
                    pack_req <= 1'b1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ot_sender_nway.sv
// tb_ot_sender_nway: directed vector bench for a 32-bit/2-message and a 64-bit/4-message sender.
module tb_ot_sender_nway;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;
    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;
    bit stall = 1'b0;

    logic a_start, a_busy, a_done, a_err, a_rng_req, a_rng_ack, a_pack_req, a_pack_ack;
    logic a_tx_valid, a_tx_ready, a_rx_valid, a_rx_ready;
    logic [31:0] a_key_n, a_key_e, a_rng_data, a_pack_v, a_pack_x, a_pack_m, a_pack_result;
    logic [63:0] a_msgs;
    logic [0:0] a_pack_idx;
    logic [7:0] a_tx_data, a_rx_data;

    logic b_start, b_busy, b_done, b_err, b_rng_req, b_rng_ack, b_pack_req, b_pack_ack;
    logic b_tx_valid, b_tx_ready, b_rx_valid, b_rx_ready;
    logic [63:0] b_key_n, b_key_e, b_rng_data, b_pack_v, b_pack_x, b_pack_m, b_pack_result;
    logic [255:0] b_msgs;
    logic [1:0] b_pack_idx;
    logic [7:0] b_tx_data, b_rx_data;

    ot_sender_nway #(.WORD_W(32), .NUM_MSG(2), .TIMEOUT_CYC(50)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .key_n(a_key_n), .key_e(a_key_e), .msgs(a_msgs),
        .busy(a_busy), .done(a_done), .err(a_err), .rng_req(a_rng_req), .rng_ack(a_rng_ack),
        .rng_data(a_rng_data), .pack_req(a_pack_req), .pack_ack(a_pack_ack), .pack_idx(a_pack_idx),
        .pack_v(a_pack_v), .pack_x(a_pack_x), .pack_m(a_pack_m), .pack_result(a_pack_result),
        .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .tx_data(a_tx_data),
        .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .rx_data(a_rx_data)
    );

    ot_sender_nway #(.WORD_W(64), .NUM_MSG(4), .TIMEOUT_CYC(50)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .key_n(b_key_n), .key_e(b_key_e), .msgs(b_msgs),
        .busy(b_busy), .done(b_done), .err(b_err), .rng_req(b_rng_req), .rng_ack(b_rng_ack),
        .rng_data(b_rng_data), .pack_req(b_pack_req), .pack_ack(b_pack_ack), .pack_idx(b_pack_idx),
        .pack_v(b_pack_v), .pack_x(b_pack_x), .pack_m(b_pack_m), .pack_result(b_pack_result),
        .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_data(b_tx_data),
        .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .rx_data(b_rx_data)
    );

    typedef struct {
        logic [31:0] n, e, r0, r1, v, m0, m1, p0, p1;
        bit stall;
        logic [127:0] hdr;
        logic [63:0] pk;
    } vec_t;
    vec_t vt [3];

    logic [7:0] aq[$];
    logic [7:0] bq[$];
    logic pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = 8'h00;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // tx_ready changes just after the edge so it is steady when sampled on the falling edge
    initial forever begin
        @(posedge clk);
        #1 a_tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!reset && pv && !pr)
            chk("tx_hold", {a_tx_valid, a_tx_data}, {1'b1, pd});
        pv = a_tx_valid;
        pr = a_tx_ready;
        pd = a_tx_data;
        if (a_tx_valid && a_tx_ready && !reset) aq.push_back(a_tx_data);
        if (b_tx_valid && b_tx_ready && !reset) bq.push_back(b_tx_data);
        if (a_err) err_cnt++;
    end

    function automatic logic a_sig(input int s);
        return s == 0 ? a_rng_req : s == 1 ? a_rx_ready : s == 2 ? a_pack_req : s == 3 ? a_done : a_tx_valid;
    endfunction

    task automatic wait_a(input int s, input string nm);
        for (int t = 0; t < 2000 && !a_sig(s); t++) @(negedge clk);
        chk(nm, a_sig(s), 1);
    endtask

    task automatic start_a(input int i);
        a_key_n = vt[i].n;
        a_key_e = vt[i].e;
        a_msgs = {vt[i].m1, vt[i].m0};
        aq.delete();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("busy_after_start", a_busy, 1);
    endtask

    task automatic rand_a(input int i);
        for (int k = 0; k < 2; k++) begin
            wait_a(0, "rng_req_seen");
            a_rng_ack = 1'b1;
            a_rng_data = k == 0 ? vt[i].r0 : vt[i].r1;
            @(negedge clk);
            a_rng_ack = 1'b0;
            a_rng_data = '0;
            chk("rng_req_gap", a_rng_req, 0);
        end
    endtask

    task automatic hdr_a(input int i);
        logic [127:0] cap = '0;
        wait_a(1, "rx_ready_seen");
        chk("hdr_len", aq.size(), 16);
        foreach (aq[j]) cap = {cap[119:0], aq[j]};
        chk("hdr_bytes", cap, vt[i].hdr);
        chk("tx_idle_in_rx", a_tx_valid, 0);
        aq.delete();
    endtask

    task automatic rx_a(input int i);
        for (int b = 0; b < 4; b++) begin
            a_rx_valid = 1'b1;
            a_rx_data = vt[i].v[8*b +: 8];
            @(negedge clk);
        end
        a_rx_valid = 1'b0;
        chk("rx_ready_drop", a_rx_ready, 0);
    endtask

    task automatic pack_a(input int i);
        logic [96:0] exp;
        for (int k = 0; k < 2; k++) begin
            wait_a(2, "pack_req_seen");
            exp = {1'(k), vt[i].v, k == 0 ? vt[i].r0 : vt[i].r1, k == 0 ? vt[i].m0 : vt[i].m1};
            chk("pack_fields", {a_pack_idx, a_pack_v, a_pack_x, a_pack_m}, exp);
            @(negedge clk);
            chk("pack_hold", {a_pack_req, a_pack_idx, a_pack_v, a_pack_x, a_pack_m}, {1'b1, exp});
            a_pack_ack = 1'b1;
            a_pack_result = k == 0 ? vt[i].p0 : vt[i].p1;
            @(negedge clk);
            a_pack_ack = 1'b0;
        end
    endtask

    task automatic fin_a(input int i);
        logic [63:0] cap = '0;
        wait_a(3, "done_seen");
        chk("busy_at_done", a_busy, 0);
        chk("pk_len", aq.size(), 8);
        foreach (aq[j]) cap = {cap[55:0], aq[j]};
        chk("pk_bytes", cap, vt[i].pk);
        @(negedge clk);
        chk("done_one_cycle", a_done, 0);
    endtask

    task automatic run_b();
        logic [63:0] cap;
        b_key_n = 64'h0123456789ABCDEF;
        b_key_e = 64'd65537;
        b_msgs = {64'd44, 64'd33, 64'd22, 64'd11};
        bq.delete();
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < 2000 && !b_rng_req; t++) @(negedge clk);
            chk("b_rng_req_seen", b_rng_req, 1);
            b_rng_ack = 1'b1;
            b_rng_data = 64'(k + 1);
            @(negedge clk);
            b_rng_ack = 1'b0;
        end
        for (int t = 0; t < 2000 && !b_rx_ready; t++) @(negedge clk);
        chk("b_rx_ready_seen", b_rx_ready, 1);
        chk("b_hdr_len", bq.size(), 48);
        cap = '0;
        if (bq.size() >= 48) for (int j = 7; j >= 0; j--) cap = {cap[55:0], bq[j]};
        chk("b_hdr_key_n", cap, 64'h0123456789ABCDEF);
        cap = '0;
        if (bq.size() >= 48) for (int j = 47; j >= 40; j--) cap = {cap[55:0], bq[j]};
        chk("b_hdr_x3", cap, 64'd4);
        bq.delete();
        for (int b = 0; b < 8; b++) begin
            b_rx_valid = 1'b1;
            b_rx_data = 8'(b + 1);
            @(negedge clk);
        end
        b_rx_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < 2000 && !b_pack_req; t++) @(negedge clk);
            chk("b_pack", {b_pack_req, b_pack_idx, b_pack_v, b_pack_x, b_pack_m},
                {1'b1, 2'(k), 64'h0807060504030201, 64'(k + 1), 64'(11 * (k + 1))});
            b_pack_ack = 1'b1;
            b_pack_result = 64'h1000 + 64'(k);
            @(negedge clk);
            b_pack_ack = 1'b0;
        end
        for (int t = 0; t < 2000 && !b_done; t++) @(negedge clk);
        chk("b_done_seen", b_done, 1);
        chk("b_pk_len", bq.size(), 32);
        cap = '0;
        if (bq.size() >= 32) for (int j = 31; j >= 24; j--) cap = {cap[55:0], bq[j]};
        chk("b_pk_last", cap, 64'h1003);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{n: 32'd128255609, e: 32'd17, r0: 32'd1, r1: 32'd6, v: 32'h11223344,
                  m0: 32'd12345, m1: 32'd67890, p0: 32'hAABBCCDD, p1: 32'h01020304, stall: 1'b0,
                  hdr: 128'h7906A507_11000000_01000000_06000000, pk: 64'hDDCCBBAA_04030201};
        vt[1] = vt[0];
        vt[1].stall = 1'b1;
        vt[2] = '{n: 32'hDEADBEEF, e: 32'h00010001, r0: 32'hCAFEF00D, r1: 32'h12345678, v: 32'h80000001,
                  m0: 32'hFFFFFFFF, m1: 32'h0, p0: 32'h0, p1: 32'hFFFFFFFF, stall: 1'b1,
                  hdr: 128'hEFBEADDE_01000100_0DF0FECA_78563412, pk: 64'h00000000_FFFFFFFF};
        {a_start, a_rng_ack, a_pack_ack, a_rx_valid, a_tx_ready} = '0;
        {a_key_n, a_key_e, a_msgs, a_rng_data, a_pack_result, a_rx_data} = '0;
        {b_start, b_rng_ack, b_pack_ack, b_rx_valid} = '0;
        b_tx_ready = 1'b1;
        {b_key_n, b_key_e, b_msgs, b_rng_data, b_pack_result, b_rx_data} = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {a_busy, a_done, a_err, a_rng_req, a_pack_req, a_pack_idx, a_pack_v, a_pack_x,
            a_pack_m, a_tx_valid, a_tx_data, a_rx_ready}, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            stall = vt[i].stall;
            start_a(i);
            rand_a(i);
            hdr_a(i);
            rx_a(i);
            pack_a(i);
            fin_a(i);
            repeat (2) @(negedge clk);
        end

        stall = 1'b0;
        start_a(0);
        rand_a(0);
        hdr_a(0);
        a_key_n = 32'h0;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        chk("start_ignored", {a_busy, a_rx_ready, a_rng_req, a_tx_valid}, 4'b1100);
        rx_a(0);
        pack_a(0);
        wait_a(4, "tx_pk_valid_seen");
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_tx_pk", {a_busy, a_done, a_err, a_rng_req, a_pack_req, a_pack_idx, a_pack_v, a_pack_x,
            a_pack_m, a_tx_valid, a_tx_data, a_rx_ready}, 0);
        reset = 1'b0;
        @(negedge clk);
        start_a(0);
        rand_a(0);
        hdr_a(0);
        rx_a(0);
        pack_a(0);
        fin_a(0);

`ifdef OT_RX_TIMEOUT_EN
        begin
            int c = 0;
            start_a(0);
            rand_a(0);
            hdr_a(0);
            for (int b = 0; b < 2; b++) begin
                a_rx_valid = 1'b1;
                a_rx_data = 8'(b + 1);
                @(negedge clk);
            end
            a_rx_valid = 1'b0;
            while (!a_err && c < 200) begin
                @(negedge clk);
                c++;
            end
            chk("timeout_cycles", c, 50);
            chk("timeout_idle", {a_busy, a_done, a_rx_ready}, 0);
            @(negedge clk);
            chk("err_one_cycle", {a_err, a_busy}, 0);
            chk("err_count", err_cnt, 1);
        end
`else
        chk("err_never", err_cnt, 0);
`endif

        run_b();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ot_sender_nway.md
Name: ot_sender_nway

Overview:
- Parametrised 1-out-of-NUM_MSG oblivious-transfer sender controller. Successor to the fixed 1-of-2, 32-bit sender.
- Sequences one protocol session over a byte stream: public key, random values, receiver's blinded word, packed messages.
- Random-word generation and modular packing stay outside the block, in the existing PRNG and RSA-pack engines. The block talks to them through req/ack handshakes and sits between those engines and the UART byte link.

Parameters:
- WORD_W, 32, protocol word width in bits; multiple of 8, 16..64.
- NUM_MSG, 2, number of messages offered; 2..8.
- TIMEOUT_CYC, 1000000, RX idle-cycle limit (used only with OT_RX_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a session when idle
- key_n  in  WORD_W  RSA modulus
- key_e  in  WORD_W  public exponent
- msgs  in  NUM_MSG*WORD_W  messages; message i at bits [i*WORD_W +: WORD_W]
- busy  out  1  session in progress
- done  out  1  one-cycle pulse at session end
- err  out  1  one-cycle pulse on aborted session
- rng_req  out  1  random-word request
- rng_ack  in  1  random word valid
- rng_data  in  WORD_W  random word
- pack_req  out  1  pack request
- pack_ack  in  1  pack result valid
- pack_idx  out  $clog2(NUM_MSG)  message index being packed
- pack_v  out  WORD_W  received blinded word
- pack_x  out  WORD_W  random value x[pack_idx]
- pack_m  out  WORD_W  message m[pack_idx]
- pack_result  in  WORD_W  packed word
- tx_valid  out  1  byte valid
- tx_ready  in  1  sink ready
- tx_data  out  8  byte
- rx_valid  in  1  byte valid
- rx_ready  out  1  block ready
- rx_data  in  8  byte

Behaviour:
- Reset:
  - all outputs 0; state IDLE; all counters 0.
  - Reset mid-session aborts immediately with no err pulse.
- key_n, key_e and msgs are sampled into registers on the accepted start.
- start while busy is ignored.
- States, in order:
  - IDLE: on start -> RAND, busy=1.
  - RAND: rng_req held high until rng_ack is sampled high. rng_data is captured as x[k] on that edge. rng_req drops for one cycle between words. After NUM_MSG words -> TX_HDR.
  - TX_HDR: send n, e, then x[0]..x[NUM_MSG-1] -> RX_V.
  - RX_V: rx_ready=1. Collect WORD_W/8 bytes into v -> PACK.
  - PACK: for i=0..NUM_MSG-1, pack_req held until pack_ack. pack_idx, pack_v, pack_x and pack_m are stable while pack_req=1. pack_result is stored as p[i]. After the last result -> TX_PK.
  - TX_PK: send p[0]..p[NUM_MSG-1] -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Word serialisation:
  - LSB byte first, WORD_W/8 bytes per word, words back-to-back.
- TX handshake (valid/ready):
  - A byte transfers on a clock where tx_valid && tx_ready.
  - tx_data must not change while tx_valid=1 and not yet accepted.
  - tx_valid must not be dropped before the byte is accepted.
  - The next byte may be presented the cycle after acceptance, giving 1 byte/cycle when tx_ready is constantly high.
  - tx_valid is 0 in every state other than TX_HDR and TX_PK.
- RX handshake:
  - A byte is accepted on rx_valid && rx_ready.
  - rx_ready=0 outside RX_V.
  - rx_ready drops in the cycle after the last byte of v is accepted.
  - Bytes arriving outside RX_V are not consumed.
- Header length: (2+NUM_MSG)*WORD_W/8 bytes. Packed length: NUM_MSG*WORD_W/8 bytes.
- Counters (byte index, word index, message index) wrap to 0 on each phase change. No counter overflow is possible within a phase.
- rng_ack outside RAND and pack_ack outside PACK are ignored.

Optional Feature:
- Macro: OT_RX_TIMEOUT_EN.
- With the macro:
  - A cycle counter runs in RX_V and is cleared on every accepted byte.
  - When it reaches TIMEOUT_CYC: err=1 for one cycle, busy=0, rx_ready=0, state -> IDLE, no done pulse.
- Without the macro: RX_V waits indefinitely and err is tied 0.

Decomposition:
- Package ot_pkg holds:
  - state enum (IDLE, RAND, TX_HDR, RX_V, PACK, TX_PK, DONE);
  - BYTE_W=8;
  - localparam function for bytes-per-word.
- One natural sub-module: ot_word_serializer. It is a WORD_W-wide load/ready interface to the byte tx valid/ready stream, containing the byte counter and hold register. It is used for both TX phases.

Test Plan:
- WORD_W=32, NUM_MSG=2, key_n=128255609, key_e=17, rng returns 1 then 6, tx_ready=1:
  - 16 bytes: 79 06 A5 07, 11 00 00 00, 01 00 00 00, 06 00 00 00;
  - then rx_ready=1.
- Same session, rx bytes 44 33 22 11:
  - pack_v=0x11223344;
  - pack_idx=0 then 1, with pack_m=12345 then 67890;
  - pack_result 0xAABBCCDD, 0x01020304 -> tx DD CC BB AA 04 03 02 01, then done pulse, busy=0.
- tx_ready toggled randomly, 50% duty: tx_data stable during every stall; identical byte sequence; no byte lost or duplicated.
- WORD_W=64, NUM_MSG=4: header=48 bytes, packed=32 bytes; pack_idx sweeps 0..3.
- Pulse start mid-RX_V (ignored); assert reset mid-TX_PK: all outputs 0 next cycle; a fresh start runs a complete session.
- OT_RX_TIMEOUT_EN with TIMEOUT_CYC=50, send 2 rx bytes then stop: err pulses 50 cycles after the last byte, state IDLE, no done.
